game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
Game-level sequencer for the space-invaders datapath. It owns lives, score, level and enemy-remaining bookkeeping, and gates the player and enemy blocks through a run enable. It emits one-cycle resume, add-life and field-clear pulses, and sits between the synchronized buttons/frame strobe and the player/enemy instances in the top module.

Parameters:
lives_p, 3, lives loaded at game start; also the cap for add_life
enemies_p, 10, enemies per wave
pause_frames_p, 60, frames spent in HIT_PAUSE / LEVEL_CLEAR before exit is allowed
score_w_p, 12, score counter width
max_level_p, 7, highest level; level saturates here

Ports:
clk_i  in  1  pixel clock
reset_i  in  1  asynchronous, active-high reset
frame_i  in  1  one-cycle strobe per frame
start_i  in  1  synchronized shoot/start button, level
player_hit_i  in  1  pulse, player struck
enemy_killed_i  in  1  pulse, one enemy destroyed
enemy_landed_i  in  1  enemy reached player row
state_o  out  3  current game_state_e
run_o  out  1  gameplay enable for player/enemy movement
resume_o  out  1  pulse, leaving HIT_PAUSE
add_life_o  out  1  pulse, life granted on level clear
clear_field_o  out  1  pulse, reload enemy fleet and bullets
lives_o  out  $clog2(lives_p+1)  lives remaining
score_o  out  score_w_p  score
level_o  out  3  current level
enemies_left_o  out  $clog2(enemies_p+1)  enemies remaining in wave

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; timer 0; start edge register 0.
- Start edge: start_q is registered. start_rise = start_i & ~start_q. A held button is one press only.
- All outputs are registered. An event sampled at edge N updates state, counters and pulses at edge N. Pulses are high for exactly one cycle.
- run_o = 1 only in PLAY.
- IDLE: on start_rise, go to PLAY. Load lives=lives_p, score=0, level=1, enemies_left=enemies_p. Pulse clear_field_o.
- PLAY, enemy_killed_i:
  - score += level, saturating at all-ones.
  - enemies_left -= 1; never decrements below 0.
- PLAY, transition priority for simultaneous events (highest first):
  1. enemy_landed_i: lives=0, go to GAME_OVER.
  2. player_hit_i with lives==1: lives=0, go to GAME_OVER.
  3. player_hit_i otherwise: lives -= 1, go to HIT_PAUSE.
  4. enemies_left reaches 0 this cycle: go to LEVEL_CLEAR.
- A kill in the same cycle as a hit or landing is still scored and decremented.
- HIT_PAUSE:
  - Timer clears on entry and increments on frame_i, saturating at pause_frames_p.
  - start_rise while timer < pause_frames_p is ignored.
  - start_rise with timer == pause_frames_p: go to PLAY and pulse resume_o. enemies_left is unchanged.
- LEVEL_CLEAR: timer as above. On the frame_i that makes timer == pause_frames_p, go to PLAY the same edge:
  - level += 1, saturating at max_level_p;
  - if lives < lives_p: lives += 1 and pulse add_life_o;
  - enemies_left = enemies_p;
  - pulse clear_field_o.
- GAME_OVER: lives, score and level hold for display. start_rise performs the same load as IDLE and goes to PLAY.
- player_hit_i, enemy_killed_i and enemy_landed_i are ignored outside PLAY.
- frame_i is ignored outside the two timed states.
- Reset asserted mid-operation returns to IDLE immediately. No pulse is emitted on reset.

Decomposition:
- game_pkg holds:
  - typedef enum logic [2:0] game_state_e {IDLE, PLAY, HIT_PAUSE, LEVEL_CLEAR, GAME_OVER};
  - localparam level width = 3.
- Sub-module frame_timer: clear input, frame_i count enable, saturating count, done output. Used once, shared by HIT_PAUSE and LEVEL_CLEAR, cleared on state entry.

Test Plan:
- Reset, then start_i held high for 100 cycles -> exactly one clear_field_o pulse. state=PLAY, lives=3, level=1, enemies_left=10, score=0. No second start is taken.
- 10 enemy_killed_i pulses at level 1 -> score=10, enemies_left=0, state=LEVEL_CLEAR. lives=3, so no add_life_o. After 60 frame_i pulses: level=2, enemies_left=10, one clear_field_o, state=PLAY.
- player_hit_i in PLAY -> lives=2, HIT_PAUSE, run_o=0. start_rise after 30 frames is ignored. start_rise after frame 60 gives one resume_o pulse and PLAY.
- player_hit_i, enemy_killed_i and enemy_landed_i in the same cycle -> GAME_OVER, lives=0, score incremented by level, enemies_left decremented.
- Hit with lives=1 -> GAME_OVER. Further hit/kill pulses change nothing. start_rise -> PLAY with lives=3, score=0, level=1.
- Reset asserted during LEVEL_CLEAR at frame 30 -> IDLE and all outputs 0 asynchronously. No pulses after release until start_rise.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared types for the game-level sequencer.
`timescale 1ns/1ps
package game_pkg;
    localparam int LEVEL_W = 3;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PLAY        = 3'd1,
        HIT_PAUSE   = 3'd2,
        LEVEL_CLEAR = 3'd3,
        GAME_OVER   = 3'd4
    } game_state_e;
endpackage

// File: rtl/game_ctrl_if.sv
// Event inputs and bookkeeping outputs of the game sequencer.
`timescale 1ns/1ps
interface game_ctrl_if
    import game_pkg::*;
#(
    parameter int lives_p   = 3,
    parameter int enemies_p = 10,
    parameter int score_w_p = 12
);
    logic                           frame_i;
    logic                           start_i;
    logic                           player_hit_i;
    logic                           enemy_killed_i;
    logic                           enemy_landed_i;
    game_state_e                    state_o;
    logic                           run_o;
    logic                           resume_o;
    logic                           add_life_o;
    logic                           clear_field_o;
    logic [$clog2(lives_p+1)-1:0]   lives_o;
    logic [score_w_p-1:0]           score_o;
    logic [LEVEL_W-1:0]             level_o;
    logic [$clog2(enemies_p+1)-1:0] enemies_left_o;

    // Stimulus side: drives the events, observes the bookkeeping.
    modport master (
        output frame_i, start_i, player_hit_i, enemy_killed_i, enemy_landed_i,
        input  state_o, run_o, resume_o, add_life_o, clear_field_o,
               lives_o, score_o, level_o, enemies_left_o
    );

    // Sequencer side.
    modport slave (
        input  frame_i, start_i, player_hit_i, enemy_killed_i, enemy_landed_i,
        output state_o, run_o, resume_o, add_life_o, clear_field_o,
               lives_o, score_o, level_o, enemies_left_o
    );
endinterface

// File: rtl/game_ctrl_frame_timer.sv
// Saturating frame counter shared by the two timed pause states.
`timescale 1ns/1ps
module frame_timer #(
    parameter int max_p = 60,
    parameter int W     = $clog2(max_p + 1)
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clear,
    input  logic         frame_i,
    output logic [W-1:0] count,
    output logic         done
);
    assign done = (count == W'(max_p));

    // Count frames while enabled, sticking at the limit; clear wins.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (frame_i && !done)
            count <= count + W'(1);
    end
endmodule

// File: rtl/game_ctrl.sv
// Game-level sequencer: lives, score, level, wave bookkeeping and run gating.
`timescale 1ns/1ps
module game_ctrl
    import game_pkg::*;
#(
    parameter int lives_p        = 3,
    parameter int enemies_p      = 10,
    parameter int pause_frames_p = 60,
    parameter int score_w_p      = 12,
    parameter int max_level_p    = 7
) (
    input  logic    clk_i,
    input  logic    reset_i,
    game_ctrl_if.slave bus
);
    localparam int LIVES_W = $clog2(lives_p + 1);
    localparam int EN_W    = $clog2(enemies_p + 1);
    localparam int TMR_W   = $clog2(pause_frames_p + 1);

    game_state_e          state;
    logic                 start_q;
    logic                 run, resume, add_life, clear_field;
    logic [LIVES_W-1:0]   lives;
    logic [score_w_p-1:0] score;
    logic [LEVEL_W-1:0]   level;
    logic [EN_W-1:0]      enemies;

    logic                 start_rise, timed, lc_exit, tmr_done;
    logic [TMR_W-1:0]     tmr_count;
    logic [score_w_p:0]   score_sum;
    logic [score_w_p-1:0] score_inc;
    logic [EN_W-1:0]      enemies_dec, enemies_nxt;

    assign start_rise  = bus.start_i & ~start_q;
    assign timed       = (state == HIT_PAUSE) || (state == LEVEL_CLEAR);
    // Level clear leaves on the frame that brings the timer to its limit.
    assign lc_exit     = bus.frame_i && (tmr_count == TMR_W'(pause_frames_p - 1));
    assign score_sum   = {1'b0, score} + {{(score_w_p + 1 - LEVEL_W){1'b0}}, level};
    assign score_inc   = score_sum[score_w_p] ? '1 : score_sum[score_w_p-1:0];
    assign enemies_dec = (enemies != '0) ? enemies - EN_W'(1) : enemies;
    assign enemies_nxt = bus.enemy_killed_i ? enemies_dec : enemies;

    // Held at zero outside the timed states, so it starts fresh on every entry.
    frame_timer #(.max_p(pause_frames_p), .W(TMR_W)) u_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear   (~timed),
        .frame_i (bus.frame_i & timed),
        .count   (tmr_count),
        .done    (tmr_done)
    );

    // Game FSM with all bookkeeping and pulse outputs registered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            run         <= 1'b0;
            resume      <= 1'b0;
            add_life    <= 1'b0;
            clear_field <= 1'b0;
            lives       <= '0;
            score       <= '0;
            level       <= '0;
            enemies     <= '0;
        end else begin
            start_q     <= bus.start_i;
            resume      <= 1'b0;
            add_life    <= 1'b0;
            clear_field <= 1'b0;
            case (state)
                IDLE, GAME_OVER: begin
                    if (start_rise) begin
                        state       <= PLAY;
                        run         <= 1'b1;
                        lives       <= LIVES_W'(lives_p);
                        score       <= '0;
                        level       <= LEVEL_W'(1);
                        enemies     <= EN_W'(enemies_p);
                        clear_field <= 1'b1;
                    end
                end
                PLAY: begin
                    // Kills are booked even when a hit or landing ends play.
                    if (bus.enemy_killed_i) begin
                        score   <= score_inc;
                        enemies <= enemies_dec;
                    end
                    if (bus.enemy_landed_i) begin
                        lives <= '0;
                        state <= GAME_OVER;
                        run   <= 1'b0;
                    end else if (bus.player_hit_i) begin
                        run <= 1'b0;
                        if (lives == LIVES_W'(1)) begin
                            lives <= '0;
                            state <= GAME_OVER;
                        end else begin
                            lives <= lives - LIVES_W'(1);
                            state <= HIT_PAUSE;
                        end
                    end else if (enemies_nxt == '0) begin
                        state <= LEVEL_CLEAR;
                        run   <= 1'b0;
                    end
                end
                HIT_PAUSE: begin
                    if (start_rise && tmr_done) begin
                        state  <= PLAY;
                        run    <= 1'b1;
                        resume <= 1'b1;
                    end
                end
                LEVEL_CLEAR: begin
                    if (lc_exit) begin
                        state       <= PLAY;
                        run         <= 1'b1;
                        enemies     <= EN_W'(enemies_p);
                        clear_field <= 1'b1;
                        if (level != LEVEL_W'(max_level_p))
                            level <= level + LEVEL_W'(1);
                        if (lives < LIVES_W'(lives_p)) begin
                            lives    <= lives + LIVES_W'(1);
                            add_life <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    run   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state_o        = state;
    assign bus.run_o          = run;
    assign bus.resume_o       = resume;
    assign bus.add_life_o     = add_life;
    assign bus.clear_field_o  = clear_field;
    assign bus.lives_o        = lives;
    assign bus.score_o        = score;
    assign bus.level_o        = level;
    assign bus.enemies_left_o = enemies;
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: scripted vector table, wave/saturation and reset
// sequences, then random events, all against a cycle-level rules model.
`timescale 1ns/1ps
module tb_game_ctrl;
    import game_pkg::*;

    localparam int LIVES = 3, EN = 10, PF = 60, SW = 12, ML = 7;
    localparam int S_IDLE = 0, S_PLAY = 1, S_HIT = 2, S_LC = 3, S_GO = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_ctrl_if #(.lives_p(LIVES), .enemies_p(EN), .score_w_p(SW)) bus ();

    game_ctrl #(
        .lives_p(LIVES), .enemies_p(EN), .pause_frames_p(PF),
        .score_w_p(SW), .max_level_p(ML)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int n_vec = 0, n_err = 0;
    int c_clr, c_res, c_add;

    // Rules model state
    int m_st, m_lives, m_score, m_level, m_en, m_tmr, m_prev;
    int m_res, m_add, m_clr;

    typedef struct {
        bit s, h, k, l, f;
        int reps;
        int st, lives, score, level, en;
        int clr, res, add;
    } vec_t;
    vec_t tbl[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_st = S_IDLE; m_lives = 0; m_score = 0; m_level = 0; m_en = 0;
        m_tmr = 0; m_prev = 0; m_res = 0; m_add = 0; m_clr = 0;
    endfunction

    function automatic void new_game();
        m_st = S_PLAY; m_lives = LIVES; m_score = 0; m_level = 1; m_en = EN;
        m_clr = 1;
    endfunction

    function automatic void model_step(bit s, bit h, bit k, bit l, bit f);
        bit rise;
        rise   = s && (m_prev == 0);
        m_prev = s;
        m_res = 0; m_add = 0; m_clr = 0;
        case (m_st)
            S_IDLE, S_GO: if (rise) new_game();
            S_PLAY: begin
                if (k) begin
                    m_score = (m_score + m_level > SMAX) ? SMAX : m_score + m_level;
                    if (m_en > 0) m_en--;
                end
                if (l) begin
                    m_lives = 0; m_st = S_GO;
                end else if (h) begin
                    if (m_lives == 1) begin
                        m_lives = 0; m_st = S_GO;
                    end else begin
                        m_lives--; m_st = S_HIT; m_tmr = 0;
                    end
                end else if (m_en == 0) begin
                    m_st = S_LC; m_tmr = 0;
                end
            end
            S_HIT: begin
                if (rise && m_tmr == PF) begin
                    m_st = S_PLAY; m_res = 1;
                end else if (f && m_tmr < PF) m_tmr++;
            end
            S_LC: begin
                if (f) begin
                    m_tmr++;
                    if (m_tmr == PF) begin
                        m_st = S_PLAY;
                        if (m_level < ML) m_level++;
                        if (m_lives < LIVES) begin
                            m_lives++; m_add = 1;
                        end
                        m_en = EN; m_clr = 1;
                    end
                end
            end
            default: m_st = S_IDLE;
        endcase
    endfunction

    task automatic check_outputs(string tag);
        check({tag, ".state"},   bus.state_o,        m_st);
        check({tag, ".run"},     bus.run_o,          (m_st == S_PLAY) ? 1 : 0);
        check({tag, ".resume"},  bus.resume_o,       m_res);
        check({tag, ".addlife"}, bus.add_life_o,     m_add);
        check({tag, ".clear"},   bus.clear_field_o,  m_clr);
        check({tag, ".lives"},   bus.lives_o,        m_lives);
        check({tag, ".score"},   bus.score_o,        m_score);
        check({tag, ".level"},   bus.level_o,        m_level);
        check({tag, ".enemies"}, bus.enemies_left_o, m_en);
    endtask

    task automatic cycle(string tag, bit s, bit h, bit k, bit l, bit f);
        @(negedge clk);
        bus.start_i = s; bus.player_hit_i = h; bus.enemy_killed_i = k;
        bus.enemy_landed_i = l; bus.frame_i = f;
        @(posedge clk);
        model_step(s, h, k, l, f);
        #1;
        check_outputs(tag);
        c_clr += int'(bus.clear_field_o);
        c_res += int'(bus.resume_o);
        c_add += int'(bus.add_life_o);
    endtask

    function automatic void row(bit s, bit h, bit k, bit l, bit f, int reps,
                                int st, int lv, int sc, int lev, int en,
                                int clr, int res, int add);
        vec_t v;
        v.s = s; v.h = h; v.k = k; v.l = l; v.f = f; v.reps = reps;
        v.st = st; v.lives = lv; v.score = sc; v.level = lev; v.en = en;
        v.clr = clr; v.res = res; v.add = add;
        tbl.push_back(v);
    endfunction

    initial begin
        bus.start_i = 0; bus.player_hit_i = 0; bus.enemy_killed_i = 0;
        bus.enemy_landed_i = 0; bus.frame_i = 0;
        model_reset();
        #1 check_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        //   s h k l f reps  state  lv score lvl en  clr res add
        row(1,0,0,0,0,100, S_PLAY, 3,  0, 1, 10,  1, 0, 0); // held start = one press
        row(0,0,1,0,0,  9, S_PLAY, 3,  9, 1,  1,  0, 0, 0);
        row(0,0,1,0,0,  1, S_LC,   3, 10, 1,  0,  0, 0, 0);
        row(0,0,0,0,1, 59, S_LC,   3, 10, 1,  0,  0, 0, 0);
        row(0,0,0,0,1,  1, S_PLAY, 3, 10, 2, 10,  1, 0, 0); // full lives: no add
        row(0,1,0,0,0,  1, S_HIT,  2, 10, 2, 10,  0, 0, 0);
        row(0,0,0,0,1, 30, S_HIT,  2, 10, 2, 10,  0, 0, 0);
        row(1,0,0,0,0,  1, S_HIT,  2, 10, 2, 10,  0, 0, 0); // early start ignored
        row(0,0,0,0,1, 30, S_HIT,  2, 10, 2, 10,  0, 0, 0);
        row(1,0,0,0,0,  1, S_PLAY, 2, 10, 2, 10,  0, 1, 0);
        row(0,0,1,0,0, 10, S_LC,   2, 30, 2,  0,  0, 0, 0);
        row(0,0,0,0,1, 60, S_PLAY, 3, 30, 3, 10,  1, 0, 1); // life granted
        row(0,1,1,1,0,  1, S_GO,   0, 33, 3,  9,  0, 0, 0); // all three at once
        row(0,1,1,1,1,  5, S_GO,   0, 33, 3,  9,  0, 0, 0); // ignored
        row(1,0,0,0,0,  1, S_PLAY, 3,  0, 1, 10,  1, 0, 0);
        row(0,1,0,0,0,  1, S_HIT,  2,  0, 1, 10,  0, 0, 0);
        row(0,0,0,0,1, 60, S_HIT,  2,  0, 1, 10,  0, 0, 0);
        row(1,0,0,0,0,  1, S_PLAY, 2,  0, 1, 10,  0, 1, 0);
        row(0,1,0,0,0,  1, S_HIT,  1,  0, 1, 10,  0, 0, 0);
        row(0,0,0,0,1, 70, S_HIT,  1,  0, 1, 10,  0, 0, 0); // timer saturates
        row(1,0,0,0,0,  1, S_PLAY, 1,  0, 1, 10,  0, 1, 0);
        row(0,1,1,0,0,  1, S_GO,   0,  1, 1,  9,  0, 0, 0); // last life
        row(0,1,1,0,1,  3, S_GO,   0,  1, 1,  9,  0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            c_clr = 0; c_res = 0; c_add = 0;
            for (int r = 0; r < tbl[i].reps; r++)
                cycle($sformatf("row%0d", i), tbl[i].s, tbl[i].h, tbl[i].k, tbl[i].l, tbl[i].f);
            check($sformatf("row%0d.tstate", i), bus.state_o,        tbl[i].st);
            check($sformatf("row%0d.tlives", i), bus.lives_o,        tbl[i].lives);
            check($sformatf("row%0d.tscore", i), bus.score_o,        tbl[i].score);
            check($sformatf("row%0d.tlevel", i), bus.level_o,        tbl[i].level);
            check($sformatf("row%0d.tenem", i),  bus.enemies_left_o, tbl[i].en);
            check($sformatf("row%0d.nclr", i),   c_clr,              tbl[i].clr);
            check($sformatf("row%0d.nres", i),   c_res,              tbl[i].res);
            check($sformatf("row%0d.nadd", i),   c_add,              tbl[i].add);
        end

        // Many waves: level saturates at the top and score at all-ones.
        cycle("waves", 1, 0, 0, 0, 0);
        for (int w = 0; w < 62; w++) begin
            repeat (EN) cycle("waves", 0, 0, 1, 0, 0);
            repeat (PF) cycle("waves", 0, 0, 0, 0, 1);
        end
        check("waves.level", bus.level_o, ML);
        check("waves.score", bus.score_o, SMAX);
        check("waves.lives", bus.lives_o, LIVES);

        // Reset in the middle of a level-clear pause, away from any edge.
        cycle("lcrst", 0, 1, 1, 1, 0);          // end that game
        cycle("lcrst", 1, 0, 0, 0, 0);
        repeat (EN) cycle("lcrst", 0, 0, 1, 0, 0);
        repeat (30) cycle("lcrst", 0, 0, 0, 0, 1);
        check("lcrst.pre_state", bus.state_o, S_LC);
        @(negedge clk);
        bus.start_i = 0; bus.frame_i = 0; bus.enemy_killed_i = 0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c_clr = 0; c_res = 0; c_add = 0;
        for (int i = 0; i < 20; i++) cycle("post_rst", 0, i[2], i[1], i[3], i[0]);
        check("post_rst.pulses", c_clr + c_res + c_add, 0);
        check("post_rst.state", bus.state_o, S_IDLE);

        // Random events against the rules model.
        for (int i = 0; i < 3000; i++)
            cycle("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 300) == 0,
                  $urandom_range(0, 1) == 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
